// File: rtl/c432_lock_pkg.sv
// c432_lock_pkg: shared widths, CRC polynomial, loader states and CRC step for the c432 key loader
package c432_lock_pkg;
    localparam int XOR_KEY_W = 39;
    localparam int MUX_KEY_W = 4;
    localparam int KEY_W     = XOR_KEY_W + MUX_KEY_W;
    localparam int CRC_W     = 8;
    localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_KEY = 3'd1,
        SHIFT_CRC = 3'd2,
        CHECK     = 3'd3,
        ARMED     = 3'd4,
        ERROR     = 3'd5
    } state_t;

    function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] c, input logic b);
        return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC8_POLY : '0);
    endfunction
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 accumulator with synchronous clear
module crc8_serial
    import c432_lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    // Clear has priority so a restarted frame never inherits a partial checksum
    always_ff @(posedge clk or posedge rst)
        if (rst)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (en)
            crc <= crc8_next(crc, bit_in);

endmodule

// File: rtl/c432_key_loader.sv
// c432_key_loader: receives a CRC-checked serial key frame and presents it to the locked c432 core
module c432_key_loader
    import c432_lock_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sin_data,
    input  logic                 sin_valid,
    output logic                 sin_ready,
    output logic [XOR_KEY_W-1:0] key_x,
    output logic [MUX_KEY_W-1:0] key_p,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err
);

    state_t           state;
    logic [5:0]       cnt;
    logic [KEY_W-1:0] shadow;
    logic [CRC_W-1:0] rx_crc;
    logic [CRC_W-1:0] crc;
    logic             restart;
    logic             xfer;
    logic             last_key;

    // A start is honoured everywhere except CHECK, which always completes
    always_comb begin
        sin_ready = (state == SHIFT_KEY) || (state == SHIFT_CRC);
        busy      = sin_ready || (state == CHECK);
        restart   = start && (state != CHECK);
        xfer      = sin_valid && sin_ready;
        last_key  = cnt == 6'(KEY_W - 1);
    end

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (restart),
        .en     (xfer && (state == SHIFT_KEY) && !restart),
        .bit_in (sin_data),
        .crc    (crc)
    );

    // Frame sequencing; key outputs only ever load from a verified shadow register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            rx_crc    <= '0;
            key_x     <= '0;
            key_p     <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else if (restart) begin
            state     <= SHIFT_KEY;
            cnt       <= '0;
            shadow    <= '0;
            rx_crc    <= '0;
            key_x     <= '0;
            key_p     <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                SHIFT_KEY:
                    if (xfer) begin
                        shadow <= {sin_data, shadow[KEY_W-1:1]};
                        cnt    <= last_key ? '0 : cnt + 6'd1;
                        state  <= last_key ? SHIFT_CRC : SHIFT_KEY;
                    end
                SHIFT_CRC:
                    if (xfer) begin
                        rx_crc <= {rx_crc[CRC_W-2:0], sin_data};
                        cnt    <= cnt + 6'd1;
                        state  <= (cnt == 6'(CRC_W - 1)) ? CHECK : SHIFT_CRC;
                    end
                CHECK:
                    if (rx_crc == crc) begin
                        key_x     <= shadow[XOR_KEY_W-1:0];
                        key_p     <= shadow[KEY_W-1:XOR_KEY_W];
                        key_valid <= 1'b1;
                        state     <= ARMED;
                    end else begin
                        err   <= 1'b1;
                        state <= ERROR;
                    end
                default: ;
            endcase
        end

endmodule

// File: tb/tb_c432_key_loader.sv
// tb_c432_key_loader: scoreboard-driven bench for the c432 key loader
module tb_c432_key_loader;
    import c432_lock_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sin_data = 1'b0;
    logic        sin_valid = 1'b0;
    logic        sin_ready;
    logic [38:0] key_x;
    logic [3:0]  key_p;
    logic        key_valid;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic [38:0] x;
        logic [3:0]  p;
        logic        v;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   cmp_n = 0;
    int   bad_n = 0;

    always #5 clk = ~clk;

    c432_key_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sin_data  (sin_data),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .key_x     (key_x),
        .key_p     (key_p),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [7:0] model_crc(input logic [42:0] k);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < 43; i++) begin
            logic fb = c[7] ^ k[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic logic [42:0] rand_key();
        return {11'($urandom), $urandom};
    endfunction

    task automatic send_bit(input logic b, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        sin_data  = b;
        sin_valid = 1'b1;
        while (!sin_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sin_ready) begin
            cmp_n++;
            bad_n++;
            $display("FAIL ready_wait: sin_ready=%0b after %0d cycles, required 1", sin_ready, n);
        end
        @(negedge clk);
        sin_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [42:0] k, input logic [7:0] c, input bit gaps);
        for (int i = 0; i < 43; i++) send_bit(k[i], gaps);
        for (int i = 7; i >= 0; i--) send_bit(c[i], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        cmp_n++; if (key_valid !== 1'b0) begin bad_n++; $display("FAIL reset_valid: got %0b want 0", key_valid); end
        cmp_n++; if (key_x !== 39'd0 || key_p !== 4'd0) begin bad_n++; $display("FAIL reset_key: got %h/%h want 0/0", key_x, key_p); end
        cmp_n++; if (busy !== 1'b0 || err !== 1'b0) begin bad_n++; $display("FAIL reset_flags: busy=%0b err=%0b want 0 0", busy, err); end
        cmp_n++; if (sin_ready !== 1'b0) begin bad_n++; $display("FAIL reset_ready: got %0b want 0", sin_ready); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cmp_n++; if (busy !== 1'b0 || sin_ready !== 1'b0) begin bad_n++; $display("FAIL idle_hold: busy=%0b ready=%0b want 0 0", busy, sin_ready); end
    endtask

    task automatic test_zero_frame();
        exp_t e;
        pulse_start();
        sb.push_back('{x: 39'd0, p: 4'd0, v: 1'b1, e: 1'b0});
        send_frame(43'd0, 8'h00, 1'b0);
        cmp_n++; if (key_valid !== 1'b0 || busy !== 1'b1) begin bad_n++; $display("FAIL zero_check_cycle: valid=%0b busy=%0b want 0 1", key_valid, busy); end
        @(negedge clk);
        e = sb.pop_front();
        cmp_n++; if (key_valid !== e.v) begin bad_n++; $display("FAIL zero_valid: got %0b want %0b", key_valid, e.v); end
        cmp_n++; if (err !== e.e) begin bad_n++; $display("FAIL zero_err: got %0b want %0b", err, e.e); end
        cmp_n++; if (key_x !== e.x || key_p !== e.p) begin bad_n++; $display("FAIL zero_key: got %h/%h want %h/%h", key_x, key_p, e.x, e.p); end
        cmp_n++; if (busy !== 1'b0) begin bad_n++; $display("FAIL zero_busy: got %0b want 0", busy); end
    endtask

    task automatic test_bad_crc();
        exp_t e;
        pulse_start();
        sb.push_back('{x: 39'd0, p: 4'd0, v: 1'b0, e: 1'b1});
        send_frame(43'd0, 8'h01, 1'b0);
        @(negedge clk);
        e = sb.pop_front();
        cmp_n++; if (err !== e.e) begin bad_n++; $display("FAIL bad_err: got %0b want %0b", err, e.e); end
        cmp_n++; if (key_valid !== e.v) begin bad_n++; $display("FAIL bad_valid: got %0b want %0b", key_valid, e.v); end
        cmp_n++; if (key_x !== e.x || key_p !== e.p) begin bad_n++; $display("FAIL bad_key: got %h/%h want %h/%h", key_x, key_p, e.x, e.p); end
        cmp_n++; if (dut.state !== ERROR) begin bad_n++; $display("FAIL bad_state: got %0d want %0d", dut.state, ERROR); end
        pulse_start();
        cmp_n++; if (err !== 1'b0 || busy !== 1'b1) begin bad_n++; $display("FAIL bad_restart: err=%0b busy=%0b want 0 1", err, busy); end
    endtask

    task automatic test_random_key();
        exp_t        e;
        logic [42:0] k;
        for (int t = 0; t < 2; t++) begin
            k = rand_key();
            k[39] = 1'b1;
            pulse_start();
            sb.push_back('{x: k[38:0], p: k[42:39], v: 1'b1, e: 1'b0});
            send_frame(k, model_crc(k), 1'b1);
            cmp_n++; if (sin_ready !== 1'b0 || key_valid !== 1'b0) begin bad_n++; $display("FAIL rand_check_cycle: ready=%0b valid=%0b want 0 0", sin_ready, key_valid); end
            @(negedge clk);
            e = sb.pop_front();
            cmp_n++; if (key_valid !== e.v || err !== e.e) begin bad_n++; $display("FAIL rand_flags: valid=%0b err=%0b want %0b %0b", key_valid, err, e.v, e.e); end
            cmp_n++; if (key_x !== e.x) begin bad_n++; $display("FAIL rand_key_x: got %h want %h", key_x, e.x); end
            cmp_n++; if (key_p !== e.p) begin bad_n++; $display("FAIL rand_key_p: got %h want %h", key_p, e.p); end
            repeat (3) @(negedge clk);
            cmp_n++; if (sin_ready !== 1'b0 || key_valid !== 1'b1 || key_x !== e.x) begin bad_n++; $display("FAIL rand_armed_hold: ready=%0b valid=%0b x=%h want 0 1 %h", sin_ready, key_valid, key_x, e.x); end
        end
    endtask

    task automatic test_reload();
        exp_t        e;
        logic [42:0] k = rand_key() | 43'h1;
        pulse_start();
        cmp_n++; if (key_valid !== 1'b0 || key_x !== 39'd0 || key_p !== 4'd0) begin bad_n++; $display("FAIL reload_clear: valid=%0b key=%h/%h want 0 0/0", key_valid, key_x, key_p); end
        cmp_n++; if (busy !== 1'b1) begin bad_n++; $display("FAIL reload_busy: got %0b want 1", busy); end
        sb.push_back('{x: k[38:0], p: k[42:39], v: 1'b1, e: 1'b0});
        send_frame(k, model_crc(k), 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        cmp_n++; if (key_valid !== e.v || key_x !== e.x || key_p !== e.p) begin bad_n++; $display("FAIL reload_key: valid=%0b key=%h/%h want %0b %h/%h", key_valid, key_x, key_p, e.v, e.x, e.p); end
    endtask

    task automatic test_abort();
        exp_t        e;
        logic [42:0] junk = rand_key();
        logic [42:0] k = rand_key();
        pulse_start();
        for (int i = 0; i < 20; i++) send_bit(junk[i], 1'b0);
        start     = 1'b1;
        sin_data  = ~k[0];
        sin_valid = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        sin_valid = 1'b0;
        sb.push_back('{x: k[38:0], p: k[42:39], v: 1'b1, e: 1'b0});
        send_frame(k, model_crc(k), 1'b0);
        @(negedge clk);
        e = sb.pop_front();
        cmp_n++; if (key_valid !== e.v || err !== e.e) begin bad_n++; $display("FAIL abort_flags: valid=%0b err=%0b want %0b %0b", key_valid, err, e.v, e.e); end
        cmp_n++; if (key_x !== e.x || key_p !== e.p) begin bad_n++; $display("FAIL abort_key: got %h/%h want %h/%h", key_x, key_p, e.x, e.p); end
    endtask

    task automatic test_async_reset();
        logic [42:0] k = rand_key();
        logic [7:0]  c = model_crc(k);
        pulse_start();
        for (int i = 0; i < 43; i++) send_bit(k[i], 1'b0);
        for (int i = 7; i > 4; i--) send_bit(c[i], 1'b0);
        cmp_n++; if (busy !== 1'b1 || sin_ready !== 1'b1) begin bad_n++; $display("FAIL arst_pre: busy=%0b ready=%0b want 1 1", busy, sin_ready); end
        #2 rst = 1'b1;
        #1;
        cmp_n++; if (busy !== 1'b0 || sin_ready !== 1'b0) begin bad_n++; $display("FAIL arst_flags: busy=%0b ready=%0b want 0 0", busy, sin_ready); end
        cmp_n++; if (key_valid !== 1'b0 || err !== 1'b0 || key_x !== 39'd0 || key_p !== 4'd0) begin bad_n++; $display("FAIL arst_outputs: valid=%0b err=%0b key=%h/%h want all 0", key_valid, err, key_x, key_p); end
        cmp_n++; if (dut.state !== IDLE) begin bad_n++; $display("FAIL arst_state: got %0d want %0d", dut.state, IDLE); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cmp_n++; if (busy !== 1'b0) begin bad_n++; $display("FAIL arst_idle: busy=%0b want 0", busy); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_bad_crc();
        test_random_key();
        test_reload();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
